// File: rtl/ram_rr_arbiter.sv
// Two-client round-robin arbiter in front of one single-port RAM, with bounded exclusive lock bursts.
// Latency: grant is combinational (same cycle as req); read data/rvalid return one cycle after the read grant.
// Backpressure: a request that is not granted simply stays pending; nothing is queued inside the arbiter.
module ram_rr_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic {OPEN, LOCKED} mode_t;

  mode_t            mode, mode_nxt;
  logic             prio, prio_nxt;
  logic             owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rv0, rv1;

  logic             lock_own;
  logic             req_own;
  logic             hold;
  logic             tie_prio;
  logic             win;
  logic             win_vld;
  logic             win_lock;

  // Arbitration and next-state: exclusive owner service while the lock holds, round-robin otherwise.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mode_nxt  = mode;
    prio_nxt  = prio;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    win       = 1'b0;
    win_vld   = 1'b0;
    win_lock  = 1'b0;
    lock_own  = owner ? lock1 : lock0;
    req_own   = owner ? req1 : req0;
    hold      = (mode == LOCKED) && lock_own && (cnt < CNT_MAX);
    // In the release cycle the non-owner gets the tie so it cannot be starved.
    tie_prio  = (mode == LOCKED) ? ~owner : prio;

    if (hold) begin
      // Counter runs whether or not the owner actually uses the slot.
      win     = owner;
      win_vld = req_own;
      cnt_nxt = cnt + 1'b1;
    end else begin
      win_vld  = req0 | req1;
      win      = (req0 & req1) ? tie_prio : req1;
      win_lock = win ? lock1 : lock0;
      mode_nxt = OPEN;
      cnt_nxt  = '0;
      if (win_vld) begin
        prio_nxt = ~win;
      end
      // The outgoing owner may not chain straight into another lock.
      if (win_vld && win_lock && !((mode == LOCKED) && (win == owner))) begin
        mode_nxt  = LOCKED;
        owner_nxt = win;
        cnt_nxt   = CNT_W'(1);
      end
    end

    if (rst_n && win_vld) begin
      gnt0 = ~win;
      gnt1 = win;
    end
  end

  // RAM port mux: granted client's fields, otherwise a harmless all-zero read.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt0) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = wdata0;
    end else if (gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = wdata1;
    end
  end

  // State registers and read-return tagging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= OPEN;
      prio  <= 1'b0;
      owner <= 1'b0;
      cnt   <= '0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      mode  <= mode_nxt;
      prio  <= prio_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      rv0   <= gnt0 & ~we0;
      rv1   <= gnt1 & ~we1;
    end
  end

  assign rvalid0 = rv0;
  assign rvalid1 = rv1;
  assign rdata0  = ram_dout;
  assign rdata1  = ram_dout;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: behavioural RAM plus a rule-level reference model of arbitration.
// Latency: outputs are sampled at the falling edge; the model advances at the rising edge.
// Backpressure: stimulus keeps an ungranted request and its fields stable until the model grants it.
module tb_ram_rr_arbiter;

  localparam int AW       = 4;
  localparam int DW       = 8;
  localparam int LOCK_MAX = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0  = 1'b0, we0 = 1'b0, lock0 = 1'b0;
  logic          req1  = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;

  logic [DW-1:0] mem [1<<AW];

  int errors = 0;
  int checks = 0;

  // Reference model state: who holds a lock (-1 none), exclusive cycles used, tie winner.
  int            m_holder = -1;
  int            m_used   = 0;
  int            m_tie    = 0;
  logic          m_rv0    = 1'b0;
  logic          m_rv1    = 1'b0;
  logic [DW-1:0] m_rdata  = '0;
  logic [DW-1:0] exp_mem [1<<AW];

  // Per-cycle observations and expectations.
  logic [24:0]   o_vec, e_vec;
  logic [1:0]    o_gnt, o_rv;
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_din, o_rdata;
  int            e_g = -1;

  ram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write at the edge, registered read-before-write output.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic set0(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic k);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = k;
  endtask

  task automatic set1(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic k);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = k;
  endtask

  function automatic logic lock_of(input int c);
    return (c == 0) ? lock0 : lock1;
  endfunction

  function automatic logic req_of(input int c);
    return (c == 0) ? req0 : req1;
  endfunction

  function automatic logic exclusive_now();
    return (m_holder >= 0) && lock_of(m_holder) && (m_used < LOCK_MAX);
  endfunction

  // Which client the rules say is granted this cycle (-1 for none).
  function automatic int model_grant();
    int tie;
    if (!rst_n) return -1;
    if (exclusive_now()) return req_of(m_holder) ? m_holder : -1;
    tie = (m_holder >= 0) ? 1 - m_holder : m_tie;
    if (req0 && req1) return tie;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic model_update(input int g);
    logic [AW-1:0] a;
    logic          excl;
    if (!rst_n) begin
      m_holder = -1; m_used = 0; m_tie = 0; m_rv0 = 1'b0; m_rv1 = 1'b0;
      return;
    end
    excl  = exclusive_now();
    m_rv0 = (g == 0) && !we0;
    m_rv1 = (g == 1) && !we1;
    if (g >= 0) begin
      a = (g == 1) ? addr1 : addr0;
      m_rdata = exp_mem[a];
      if ((g == 1) ? we1 : we0) exp_mem[a] = (g == 1) ? wdata1 : wdata0;
    end
    if (excl) begin
      m_used++;
    end else begin
      if (g >= 0) m_tie = 1 - g;
      if (g >= 0 && lock_of(g) && g != m_holder) begin
        m_holder = g; m_used = 1;
      end else begin
        m_holder = -1; m_used = 0;
      end
    end
  endtask

  // Advance one cycle: sample at the falling edge, then step the model at the rising edge.
  task automatic tick();
    int            g;
    logic          e_we, e_rv0, e_rv1;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rd;
    @(negedge clk);
    g      = model_grant();
    e_g    = g;
    e_we   = (g == 0) ? we0 : ((g == 1) ? we1 : 1'b0);
    e_addr = (g == 0) ? addr0 : ((g == 1) ? addr1 : '0);
    e_din  = (g == 0) ? wdata0 : ((g == 1) ? wdata1 : '0);
    e_rv0  = m_rv0 & rst_n;
    e_rv1  = m_rv1 & rst_n;
    e_rd   = (e_rv0 | e_rv1) ? m_rdata : '0;
    o_gnt   = {gnt1, gnt0};
    o_rv    = {rvalid1, rvalid0};
    o_we    = ram_we;
    o_addr  = ram_addr;
    o_din   = ram_din;
    o_rdata = rvalid1 ? rdata1 : (rvalid0 ? rdata0 : '0);
    o_vec = {gnt1, gnt0, ram_we, ram_addr, ram_din, rvalid1, rvalid0, o_rdata};
    e_vec = {(g == 1), (g == 0), e_we, e_addr, e_din, e_rv1, e_rv0, e_rd};
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set0(0, 0, '0, '0, 0);
    set1(0, 0, '0, '0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set0(1, 1, 4'd0, 8'h5A, 0);
    set1(1, 1, 4'd5, 8'h6B, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({o_gnt, o_rv, o_we} !== 5'b0) begin errors++; $display("FAIL reset_outputs cyc=%0d got=%b exp=00000", i, {o_gnt, o_rv, o_we}); end
      checks++; if ({o_addr, o_din} !== 12'h000) begin errors++; $display("FAIL reset_ram_bus cyc=%0d got=%h exp=000", i, {o_addr, o_din}); end
      checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", i, o_vec, e_vec); end
    end
    rst_n = 1'b1;
    tick();
    checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL reset_first_tie got=%b exp=01", o_gnt); end
    checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL reset_first_model got=%h exp=%h", o_vec, e_vec); end
    set0(0, 0, '0, '0, 0);
    tick();
    checks++; if (o_gnt !== 2'b10) begin errors++; $display("FAIL reset_pending1 got=%b exp=10", o_gnt); end
    set1(0, 0, '0, '0, 0);
  endtask

  task automatic test_write_read();
    apply_reset();
    set0(1, 1, 4'd3, 8'hA5, 0);
    tick();
    checks++; if ({o_gnt, o_we, o_addr, o_din} !== {2'b01, 1'b1, 4'd3, 8'hA5}) begin errors++; $display("FAIL wr_issue got=%h exp=%h", {o_gnt, o_we, o_addr, o_din}, {2'b01, 1'b1, 4'd3, 8'hA5}); end
    set0(1, 0, 4'd3, 8'h00, 0);
    tick();
    checks++; if ({o_gnt, o_we, o_addr} !== {2'b01, 1'b0, 4'd3}) begin errors++; $display("FAIL rd_issue got=%h exp=%h", {o_gnt, o_we, o_addr}, {2'b01, 1'b0, 4'd3}); end
    checks++; if (o_rv !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=00", o_rv); end
    set0(0, 0, '0, '0, 0);
    tick();
    checks++; if ({o_rv, o_rdata} !== {2'b01, 8'hA5}) begin errors++; $display("FAIL rd_return got=%h exp=%h", {o_rv, o_rdata}, {2'b01, 8'hA5}); end
    checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL wr_rd_model got=%h exp=%h", o_vec, e_vec); end
  endtask

  task automatic test_fairness();
    logic [1:0]    eg;
    logic [DW-1:0] ed;
    apply_reset();
    set0(1, 1, 4'd1, 8'h11, 0);
    set1(1, 1, 4'd2, 8'h22, 0);
    tick();
    set0(0, 0, '0, '0, 0);
    tick();
    set0(1, 0, 4'd1, 8'h00, 0);
    set1(1, 0, 4'd2, 8'h00, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin set0(0, 0, '0, '0, 0); set1(0, 0, '0, '0, 0); end
      tick();
      eg = (i == 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (o_gnt !== eg) begin errors++; $display("FAIL fair_grant cyc=%0d got=%b exp=%b", i, o_gnt, eg); end
      if (i > 0) begin
        eg = (i % 2 == 1) ? 2'b01 : 2'b10;
        ed = (i % 2 == 1) ? 8'h11 : 8'h22;
        checks++; if ({o_rv, o_rdata} !== {eg, ed}) begin errors++; $display("FAIL fair_rdata cyc=%0d got=%h exp=%h", i, {o_rv, o_rdata}, {eg, ed}); end
      end
    end
  endtask

  task automatic test_lock_bound();
    logic [1:0] eg;
    apply_reset();
    set0(1, 0, 4'd1, 8'h00, 1);
    set1(1, 0, 4'd2, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      eg = (i < LOCK_MAX) ? 2'b01 : ((i == LOCK_MAX) ? 2'b10 : ((i % 2 == 1) ? 2'b01 : 2'b10));
      checks++; if (o_gnt !== eg) begin errors++; $display("FAIL lock_bound cyc=%0d got=%b exp=%b", i, o_gnt, eg); end
      checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL lock_model cyc=%0d got=%h exp=%h", i, o_vec, e_vec); end
      if (i == LOCK_MAX) lock0 = 1'b0;
    end
    set0(0, 0, '0, '0, 0);
    set1(0, 0, '0, '0, 0);
  endtask

  task automatic test_early_unlock();
    apply_reset();
    set0(1, 0, 4'd1, 8'h00, 1);
    set1(1, 0, 4'd2, 8'h00, 0);
    tick();
    checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL early_lock_grant got=%b exp=01", o_gnt); end
    lock0 = 1'b0;
    tick();
    checks++; if (o_gnt !== 2'b10) begin errors++; $display("FAIL early_unlock got=%b exp=10", o_gnt); end
    checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL early_model got=%h exp=%h", o_vec, e_vec); end
    set0(0, 0, '0, '0, 0);
    set1(0, 0, '0, '0, 0);
    tick();
  endtask

  task automatic test_idle_lock();
    logic [1:0] eg;
    apply_reset();
    set0(1, 0, 4'd1, 8'h00, 1);
    set1(1, 0, 4'd2, 8'h00, 0);
    tick();
    checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL idle_lock_grant got=%b exp=01", o_gnt); end
    req0 = 1'b0;
    for (int i = 1; i <= LOCK_MAX; i++) begin
      tick();
      eg = (i < LOCK_MAX) ? 2'b00 : 2'b10;
      checks++; if (o_gnt !== eg) begin errors++; $display("FAIL idle_lock cyc=%0d got=%b exp=%b", i, o_gnt, eg); end
      checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL idle_model cyc=%0d got=%h exp=%h", i, o_vec, e_vec); end
    end
    set0(0, 0, '0, '0, 0);
    set1(0, 0, '0, '0, 0);
    tick();
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    set1(1, 0, 4'd2, 8'h00, 1);
    tick();
    checks++; if (o_gnt !== 2'b10) begin errors++; $display("FAIL mid_lock_start got=%b exp=10", o_gnt); end
    set0(1, 0, 4'd1, 8'h00, 0);
    tick();
    checks++; if (o_gnt !== 2'b10) begin errors++; $display("FAIL mid_locked_read got=%b exp=10", o_gnt); end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({o_gnt, o_rv} !== 4'b0000) begin errors++; $display("FAIL mid_reset_drop cyc=%0d got=%b exp=0000", i, {o_gnt, o_rv}); end
    end
    rst_n = 1'b1;
    lock1 = 1'b0;
    tick();
    checks++; if (o_gnt !== 2'b01) begin errors++; $display("FAIL mid_post_tie got=%b exp=01", o_gnt); end
    set0(0, 0, '0, '0, 0);
    tick();
    checks++; if ({o_gnt, o_rv, o_rdata} !== {2'b10, 2'b01, 8'h11}) begin errors++; $display("FAIL mid_post_read got=%h exp=%h", {o_gnt, o_rv, o_rdata}, {2'b10, 2'b01, 8'h11}); end
    set1(0, 0, '0, '0, 0);
    tick();
    checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL mid_post_model got=%h exp=%h", o_vec, e_vec); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int a = 0; a < (1 << AW); a++) begin
      set0(1, 1, AW'(a), DW'($urandom), 0);
      tick();
      checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL rnd_fill a=%0d got=%h exp=%h", a, o_vec, e_vec); end
    end
    set0(0, 0, '0, '0, 0);
    e_g = -1;
    for (int i = 0; i < 400; i++) begin
      if (!(req0 && e_g != 0))
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
      if (!(req1 && e_g != 1))
        set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
      tick();
      checks++; if (o_vec !== e_vec) begin errors++; $display("FAIL rnd_model cyc=%0d got=%h exp=%h", i, o_vec, e_vec); end
      checks++; if (o_gnt === 2'b11) begin errors++; $display("FAIL rnd_one_grant cyc=%0d got=%b exp=not 11", i, o_gnt); end
    end
    set0(0, 0, '0, '0, 0);
    set1(0, 0, '0, '0, 0);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) exp_mem[a] = '0;
    #1;
    test_reset();
    test_write_read();
    test_fairness();
    test_lock_bound();
    test_early_unlock();
    test_idle_lock();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
